// File: rtl/wb_write_sequencer.sv
// Y86 write-back sequencer: decodes dstE/dstM for a retired instruction and drives the
// register file's single write port, one write per cycle. Optional macro: WB_BYPASS_EN.
module wb_write_sequencer #(
    parameter int unsigned W     = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [W-1:0]     valE,
    input  logic [W-1:0]     valM,
    output logic             wr_en,
    output logic [3:0]       wr_addr,
    output logic [W-1:0]     wr_data,
    output logic [CNT_W-1:0] retire_cnt
`ifdef WB_BYPASS_EN
    ,
    output logic [3:0]       fwd_e_dst,
    output logic [W-1:0]     fwd_e_val,
    output logic [3:0]       fwd_m_dst,
    output logic [W-1:0]     fwd_m_val
`endif
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_E,
        S_WR_M
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_dst_m;
    logic [W-1:0]     r_val_m;
    logic             r_wr_en;
    logic [3:0]       r_wr_addr;
    logic [W-1:0]     r_wr_data;
    logic [CNT_W-1:0] r_retire_cnt;
`ifdef WB_BYPASS_EN
    logic [3:0]       r_dst_e;
    logic [W-1:0]     r_val_e;
`endif

    logic             w_in_ready;
    logic             w_accept;
    logic [3:0]       w_dst_e_raw;
    logic [3:0]       w_dst_e;
    logic [3:0]       w_dst_m;
    logic             w_wr_en_nxt;
    logic [3:0]       w_wr_addr_nxt;
    logic [W-1:0]     w_wr_data_nxt;

    always_comb begin
        w_dst_e_raw = REG_NONE;
        case (icode)
            4'h2:                      w_dst_e_raw = cnd ? rB : REG_NONE;
            4'h3, 4'h6:                w_dst_e_raw = rB;
            4'h8, 4'h9, 4'hA, 4'hB:    w_dst_e_raw = REG_RSP;
            default:                   w_dst_e_raw = REG_NONE;
        endcase
        w_dst_m = ((icode == 4'h5) || (icode == 4'hB)) ? rA : REG_NONE;
        // popq %rsp: the memory value wins, so the E write is dropped entirely
        w_dst_e = ((w_dst_e_raw == w_dst_m) && (w_dst_m != REG_NONE)) ? REG_NONE : w_dst_e_raw;
    end

    assign w_in_ready = !rst && ((r_state == S_IDLE) || (r_state == S_WR_M) ||
                                 ((r_state == S_WR_E) && (r_dst_m == REG_NONE)));
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dst_m      <= REG_NONE;
            r_val_m      <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= REG_NONE;
            r_wr_data    <= '0;
            r_retire_cnt <= '0;
`ifdef WB_BYPASS_EN
            r_dst_e      <= REG_NONE;
            r_val_e      <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            if (w_accept) begin
                r_dst_m      <= w_dst_m;
                r_val_m      <= valM;
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end else if (r_state == S_WR_M) begin
                r_dst_m <= REG_NONE;
            end
`ifdef WB_BYPASS_EN
            if (w_accept) begin
                r_dst_e <= w_dst_e;
                r_val_e <= valE;
            end else if (r_state == S_WR_E) begin
                r_dst_e <= REG_NONE;
            end
`endif
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        if ((r_state == S_WR_E) && (r_dst_m != REG_NONE)) begin
            w_state_nxt = S_WR_M;
        end else if (w_accept) begin
            if (w_dst_e != REG_NONE) begin
                w_state_nxt = S_WR_E;
            end else if (w_dst_m != REG_NONE) begin
                w_state_nxt = S_WR_M;
            end
        end
    end

    // Write-port values are registered from the next state so they appear
    // in the same cycle the FSM sits in WR_E/WR_M.
    always_comb begin
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = REG_NONE;
        w_wr_data_nxt = r_wr_data;
        case (w_state_nxt)
            S_WR_E: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = w_dst_e;
                w_wr_data_nxt = valE;
            end
            S_WR_M: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = w_accept ? w_dst_m : r_dst_m;
                w_wr_data_nxt = w_accept ? valM : r_val_m;
            end
            default: begin
                w_wr_en_nxt   = 1'b0;
            end
        endcase
    end

    assign in_ready   = w_in_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign retire_cnt = r_retire_cnt;
`ifdef WB_BYPASS_EN
    assign fwd_e_dst  = r_dst_e;
    assign fwd_e_val  = r_val_e;
    assign fwd_m_dst  = r_dst_m;
    assign fwd_m_val  = r_val_m;
`endif

endmodule
